// File: rtl/axi_read_responder.sv
// AXI4 read-channel responder backed by a word-addressed 64-bit memory.
// Accepts one AR request at a time, waits a programmable latency, then
// streams ARLEN+1 R beats (FIXED/INCR). Unsupported bursts or sizes get
// SLVERR; addresses outside the array get DECERR. A preload port can
// write the array at any time.
module axi_read_responder #(
    parameter logic [63:0] MEM_BASE  = 64'h8000_0000,
    parameter int          MEM_WORDS = 4096,
    parameter int          LATENCY   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [3:0]                    ARID,
    input  logic [63:0]                   ARADDR,
    input  logic [7:0]                    ARLEN,
    input  logic [2:0]                    ARSIZE,
    input  logic [1:0]                    ARBURST,
    input  logic                          ARVALID,
    output logic                          ARREADY,
    output logic [3:0]                    RID,
    output logic [63:0]                   RDATA,
    output logic [1:0]                    RRESP,
    output logic                          RLAST,
    output logic                          RVALID,
    input  logic                          RREADY,
    input  logic                          ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0]  ld_addr,
    input  logic [63:0]                   ld_data
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam logic [63:0] MEM_TOP = MEM_BASE + (64'(MEM_WORDS) << 3);
    localparam logic [3:0]  LAT_M1  = 4'(LATENCY - 1);

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_BURST = 2'b10
    } state_t;

    // Byte address falls inside the backing array.
    function automatic logic in_array(input logic [63:0] a);
        return (a >= MEM_BASE) && (a < MEM_TOP);
    endfunction

    logic [63:0] mem_r [MEM_WORDS];

    state_t      state_r, state_nxt;
    logic [3:0]  cnt_r, cnt_nxt;
    logic [3:0]  id_r, id_nxt;
    logic [63:0] addr_r, addr_nxt;
    logic [7:0]  len_r, len_nxt;
    logic [2:0]  size_r, size_nxt;
    logic [1:0]  burst_r, burst_nxt;
    logic [1:0]  resp_r, resp_nxt;
    logic [7:0]  beat_r, beat_nxt;
    logic        arready_r, arready_nxt;
    logic        rvalid_r, rvalid_nxt;
    logic        rlast_r, rlast_nxt;
    logic [63:0] rdata_r, rdata_nxt;

    logic [63:0] ar_last_addr_s;
    logic [1:0]  ar_resp_s;
    logic [63:0] next_addr_s;
    logic [63:0] beat_addr_s;
    logic [63:0] word_off_s;
    logic [63:0] mem_word_s;
    logic [63:0] beat_data_s;
    logic [7:0]  beat_inc_s;

    assign ARREADY = arready_r;
    assign RID     = id_r;
    assign RDATA   = rdata_r;
    assign RRESP   = resp_r;
    assign RLAST   = rlast_r;
    assign RVALID  = rvalid_r;

    // Preload port: plain synchronous write, independent of the FSM.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_r[ld_addr] <= ld_data;
        end
    end

    // Classify the incoming request; the result is frozen at capture.
    always_comb begin
        ar_last_addr_s = ARADDR;
        ar_resp_s      = RESP_OKAY;
        if (ARBURST == BURST_INCR) begin
            ar_last_addr_s = ARADDR + ({56'd0, ARLEN} << ARSIZE);
        end else begin
            ar_last_addr_s = ARADDR;
        end
        if (ARBURST[1] || (ARSIZE > 3'd3)) begin
            ar_resp_s = RESP_SLVERR;
        end else if (!in_array(ARADDR) || !in_array(ar_last_addr_s)) begin
            ar_resp_s = RESP_DECERR;
        end else begin
            ar_resp_s = RESP_OKAY;
        end
    end

    // Beat datapath: address of the beat about to be loaded and its data.
    always_comb begin
        next_addr_s = addr_r;
        beat_addr_s = addr_r;
        beat_inc_s  = 8'(beat_r + 8'd1);
        if (burst_r == BURST_FIXED) begin
            next_addr_s = addr_r;
        end else begin
            next_addr_s = addr_r + (64'd1 << size_r);
        end
        // Beat 0 is loaded from WAIT using the captured address; later
        // beats are loaded on a handshake using the advanced address.
        if (state_r == ST_WAIT) begin
            beat_addr_s = addr_r;
        end else begin
            beat_addr_s = next_addr_s;
        end
        word_off_s = (beat_addr_s - MEM_BASE) >> 3;
        mem_word_s = mem_r[word_off_s[AW-1:0]];
        if (resp_r == RESP_OKAY) begin
            beat_data_s = mem_word_s >> {beat_addr_s[2:0], 3'b000};
        end else begin
            beat_data_s = 64'd0;
        end
    end

    // Next-state and next-output logic for the IDLE/WAIT/BURST sequencer.
    always_comb begin
        state_nxt   = state_r;
        cnt_nxt     = cnt_r;
        id_nxt      = id_r;
        addr_nxt    = addr_r;
        len_nxt     = len_r;
        size_nxt    = size_r;
        burst_nxt   = burst_r;
        resp_nxt    = resp_r;
        beat_nxt    = beat_r;
        arready_nxt = arready_r;
        rvalid_nxt  = rvalid_r;
        rlast_nxt   = rlast_r;
        rdata_nxt   = rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (ARVALID && arready_r) begin
                    id_nxt      = ARID;
                    addr_nxt    = ARADDR;
                    len_nxt     = ARLEN;
                    size_nxt    = ARSIZE;
                    burst_nxt   = ARBURST;
                    resp_nxt    = ar_resp_s;
                    beat_nxt    = 8'd0;
                    cnt_nxt     = LAT_M1;
                    arready_nxt = 1'b0;
                    state_nxt   = ST_WAIT;
                end else begin
                    // Also raises ARREADY on the first edge after reset.
                    arready_nxt = 1'b1;
                end
            end
            ST_WAIT: begin
                arready_nxt = 1'b0;
                if (cnt_r == 4'd0) begin
                    state_nxt  = ST_BURST;
                    rvalid_nxt = 1'b1;
                    rdata_nxt  = beat_data_s;
                    rlast_nxt  = (len_r == 8'd0);
                end else begin
                    cnt_nxt = cnt_r - 4'd1;
                end
            end
            ST_BURST: begin
                arready_nxt = 1'b0;
                if (rvalid_r && RREADY) begin
                    if (rlast_r) begin
                        state_nxt   = ST_IDLE;
                        rvalid_nxt  = 1'b0;
                        rlast_nxt   = 1'b0;
                        arready_nxt = 1'b1;
                    end else begin
                        addr_nxt  = next_addr_s;
                        beat_nxt  = beat_inc_s;
                        rdata_nxt = beat_data_s;
                        rlast_nxt = (beat_inc_s == len_r);
                    end
                end else begin
                    // Stall: hold the presented beat unchanged.
                    state_nxt = ST_BURST;
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                arready_nxt = 1'b0;
                rvalid_nxt  = 1'b0;
                rlast_nxt   = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 4'd0;
            id_r      <= 4'd0;
            addr_r    <= 64'd0;
            len_r     <= 8'd0;
            size_r    <= 3'd0;
            burst_r   <= 2'b00;
            resp_r    <= RESP_OKAY;
            beat_r    <= 8'd0;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rlast_r   <= 1'b0;
            rdata_r   <= 64'd0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            id_r      <= id_nxt;
            addr_r    <= addr_nxt;
            len_r     <= len_nxt;
            size_r    <= size_nxt;
            burst_r   <= burst_nxt;
            resp_r    <= resp_nxt;
            beat_r    <= beat_nxt;
            arready_r <= arready_nxt;
            rvalid_r  <= rvalid_nxt;
            rlast_r   <= rlast_nxt;
            rdata_r   <= rdata_nxt;
        end
    end

endmodule

// File: tb/tb_axi_read_responder.sv
// Self-checking bench for axi_read_responder: directed scenarios plus
// randomized requests, compared against a per-beat reference model.
module tb_axi_read_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          WORDS = 4096;
    localparam int          LAT   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ARID;
    logic [63:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [3:0]  RID;
    logic [63:0] RDATA;
    logic [1:0]  RRESP;
    logic        RLAST;
    logic        RVALID;
    logic        RREADY;
    logic        ld_en;
    logic [11:0] ld_addr;
    logic [63:0] ld_data;

    axi_read_responder #(
        .MEM_BASE (BASE),
        .MEM_WORDS(WORDS),
        .LATENCY  (LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
        .ARBURST(ARBURST), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST),
        .RVALID(RVALID), .RREADY(RREADY),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic [3:0]  exp_id;
    logic [63:0] ref_mem [WORDS];
    bit          pat_q[$];

    function automatic bit in_arr(input logic [63:0] a);
        return (a >= BASE) && (a < BASE + 64'(WORDS) * 64'd8);
    endfunction

    // Reference: every beat address computed directly as start + k*step.
    function automatic void build_expected(input logic [3:0] id, input logic [63:0] addr,
                                           input logic [7:0] len, input logic [2:0] size,
                                           input logic [1:0] burst);
        logic [1:0]  resp;
        logic [63:0] step, a, last_a, widx;
        beat_t       b;
        step   = (burst == 2'b01) ? (64'd1 << size) : 64'd0;
        last_a = addr + 64'(len) * step;
        if (burst > 2'b01 || size > 3'd3)            resp = 2'b10;
        else if (!in_arr(addr) || !in_arr(last_a))   resp = 2'b11;
        else                                         resp = 2'b00;
        exp_q.delete();
        exp_id = id;
        for (int k = 0; k <= int'(len); k++) begin
            a      = addr + 64'(k) * step;
            widx   = (a - BASE) / 64'd8;
            b.data = (resp == 2'b00) ? (ref_mem[widx[11:0]] >> (8 * int'(a[2:0]))) : 64'd0;
            b.resp = resp;
            b.last = (k == int'(len));
            exp_q.push_back(b);
        end
    endfunction

    task automatic preload(input int idx, input logic [63:0] d);
        ld_en   = 1'b1;
        ld_addr = 12'(idx);
        ld_data = d;
        @(posedge clk); #1;
        ld_en = 1'b0;
        ref_mem[idx] = d;
    endtask

    // Issues an AR; returns 1ns after the handshake edge.
    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        int w = 0;
        ARID = id; ARADDR = addr; ARLEN = len; ARSIZE = size; ARBURST = burst;
        ARVALID = 1'b1;
        while (ARREADY !== 1'b1 && w < 50) begin
            @(posedge clk); #1;
            w++;
        end
        n_tests++;
        if (ARREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_accept: ARREADY=%b required 1", ARREADY);
        end
        @(posedge clk); #1;
        ARVALID = 1'b0;
        build_expected(id, addr, len, size, burst);
    endtask

    // Drains one burst. mode 0: RREADY high, 1: random, 2: pat_q pattern.
    task automatic collect(input int mode, input bit chk_lat, input string nm);
        int          cyc = 0;
        int          pidx = 0;
        bit          seen = 0, stalled = 0, cont = 0, done = 0, rr;
        logic [71:0] held = 72'd0;
        beat_t       b;
        while (!done && cyc < 300) begin
            if (RVALID === 1'b1 && !seen) begin
                seen = 1;
                if (chk_lat) begin
                    n_tests++;
                    if (cyc != LAT) begin
                        n_fail++;
                        $display("FAIL %s latency: first RVALID after %0d cycles, required %0d", nm, cyc, LAT);
                    end
                end
            end
            if (cont) begin
                n_tests++;
                if (RVALID !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s throughput: RVALID=%b after beat handshake, required 1", nm, RVALID);
                end
            end
            if (stalled) begin
                n_tests++;
                if ({RID, RDATA, RRESP, RLAST, RVALID} !== held) begin
                    n_fail++;
                    $display("FAIL %s stall_hold: got %h required %h", nm, {RID, RDATA, RRESP, RLAST, RVALID}, held);
                end
            end
            n_tests++;
            if (ARREADY !== 1'b0) begin
                n_fail++;
                $display("FAIL %s busy_arready: ARREADY=%b required 0", nm, ARREADY);
            end
            case (mode)
                0:       rr = 1'b1;
                1:       rr = 1'($urandom_range(0, 1));
                default: rr = (pidx < pat_q.size()) ? pat_q[pidx] : 1'b1;
            endcase
            RREADY  = rr;
            stalled = 0;
            cont    = 0;
            if (RVALID === 1'b1) begin
                pidx++;
                if (rr) begin
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL %s extra_beat: unexpected beat data=%h", nm, RDATA);
                        done = 1;
                    end else begin
                        b = exp_q.pop_front();
                        if ({RID, RDATA, RRESP, RLAST} !== {exp_id, b.data, b.resp, b.last}) begin
                            n_fail++;
                            $display("FAIL %s beat: got id=%h data=%h resp=%b last=%b, required id=%h data=%h resp=%b last=%b",
                                     nm, RID, RDATA, RRESP, RLAST, exp_id, b.data, b.resp, b.last);
                        end
                        if (b.last) done = 1;
                        else        cont = 1;
                    end
                end else begin
                    stalled = 1;
                    held    = {RID, RDATA, RRESP, RLAST, RVALID};
                end
            end
            @(posedge clk); #1;
            cyc++;
        end
        RREADY = 1'b0;
        n_tests++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: %0d beats still outstanding", nm, exp_q.size());
        end else if ({RVALID, RLAST, ARREADY} !== 3'b001) begin
            n_fail++;
            $display("FAIL %s end_state: RVALID,RLAST,ARREADY=%b required 001", nm, {RVALID, RLAST, ARREADY});
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; ARVALID = 1'b1; ARADDR = BASE; ARID = 4'd5; RREADY = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            n_tests++;
            if ({ARREADY, RVALID, RLAST, RID, RDATA, RRESP} !== 73'd0) begin
                n_fail++;
                $display("FAIL reset_values: got %h required 0", {ARREADY, RVALID, RLAST, RID, RDATA, RRESP});
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
        n_tests++;
        if (ARREADY !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: ARREADY=%b required 1", ARREADY);
        end
        ARVALID = 1'b0;
    endtask

    task automatic test_fetch;
        preload(1, 64'h1122_3344_5566_7788);
        send_ar(4'd0, BASE + 64'd4, 8'd0, 3'd2, 2'b01);
        collect(0, 1'b1, "fetch");
    endtask

    task automatic test_burst_backpressure;
        for (int i = 0; i < 4; i++) preload(i, 64'hA0 + 64'(i));
        pat_q = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        send_ar(4'd1, BASE, 8'd3, 3'd3, 2'b01);
        collect(2, 1'b1, "burst_bp");
    endtask

    task automatic test_decerr;
        send_ar(4'd3, 64'h7000_0000, 8'd1, 3'd3, 2'b01);
        collect(1, 1'b1, "decerr_low");
        send_ar(4'd4, BASE + 64'(WORDS) * 64'd8 - 64'd8, 8'd1, 3'd3, 2'b01);
        collect(1, 1'b1, "decerr_top");
    endtask

    task automatic test_slverr;
        send_ar(4'd5, BASE, 8'd0, 3'd3, 2'b10);
        collect(0, 1'b1, "slverr_wrap");
        send_ar(4'd6, BASE, 8'd0, 3'd4, 2'b01);
        collect(0, 1'b1, "slverr_size");
    endtask

    task automatic test_back_to_back;
        send_ar(4'd0, BASE + 64'd8, 8'd0, 3'd3, 2'b01);
        ARID = 4'd1; ARADDR = BASE + 64'd16; ARLEN = 8'd1; ARSIZE = 3'd3; ARBURST = 2'b01;
        ARVALID = 1'b1;
        collect(0, 1'b1, "b2b_first");
        @(posedge clk); #1;
        n_tests++;
        if (ARREADY !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept: ARREADY=%b one cycle after last beat, required 0", ARREADY);
        end
        ARVALID = 1'b0;
        build_expected(4'd1, BASE + 64'd16, 8'd1, 3'd3, 2'b01);
        collect(0, 1'b1, "b2b_second");
    endtask

    task automatic test_reset_mid_burst;
        int hs = 0, cyc = 0;
        send_ar(4'd2, BASE, 8'd3, 3'd3, 2'b01);
        RREADY = 1'b1;
        while (hs < 2 && cyc < 50) begin
            if (RVALID === 1'b1) hs++;
            @(posedge clk); #1;
            cyc++;
        end
        n_tests++;
        if (hs < 2) begin
            n_fail++;
            $display("FAIL midrst_setup: %0d beats seen, required 2", hs);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_tests++;
        if ({RVALID, RLAST, ARREADY, RID, RDATA, RRESP} !== 73'd0) begin
            n_fail++;
            $display("FAIL midrst_outputs: got %h required 0", {RVALID, RLAST, ARREADY, RID, RDATA, RRESP});
        end
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            n_tests++;
            if (RVALID !== 1'b0 || ARREADY !== 1'b1) begin
                n_fail++;
                $display("FAIL midrst_quiet: RVALID=%b ARREADY=%b required 0/1", RVALID, ARREADY);
            end
        end
        RREADY = 1'b0;
    endtask

    task automatic test_random;
        logic [63:0] addr, span;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        int          sel;
        for (int i = 0; i < 64; i++) preload(i, {$urandom, $urandom});
        for (int t = 0; t < 40; t++) begin
            sel   = int'($urandom_range(0, 9));
            len   = 8'($urandom_range(0, 7));
            size  = 3'($urandom_range(0, 3));
            burst = 2'($urandom_range(0, 1));
            span  = (burst == 2'b01) ? (64'(len) << size) : 64'd0;
            addr  = BASE + 64'($urandom_range(0, 511 - int'(span)));
            if (sel == 0) begin
                burst = 2'($urandom_range(2, 3));
            end else if (sel == 1) begin
                size = 3'($urandom_range(4, 7));
            end else if (sel == 2) begin
                if ($urandom_range(0, 1) == 1) addr = BASE - 64'($urandom_range(1, 64));
                else                           addr = BASE + 64'(WORDS) * 64'd8 + 64'($urandom_range(0, 64));
            end
            send_ar(4'($urandom_range(0, 15)), addr, len, size, burst);
            collect(1, 1'b1, "random");
        end
    endtask

    initial begin
        rst = 1'b1; ARID = 4'd0; ARADDR = 64'd0; ARLEN = 8'd0; ARSIZE = 3'd0; ARBURST = 2'b00;
        ARVALID = 1'b0; RREADY = 1'b0; ld_en = 1'b0; ld_addr = 12'd0; ld_data = 64'd0;
        test_reset();
        test_fetch();
        test_burst_backpressure();
        test_decerr();
        test_slverr();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

endmodule
